fb_fill_dma: RTL and testbench
==============================

FB_FILL_DMA -- requirements
Module: fb_fill_dma

Interface
REQ-001 Parameter csr_addr, default 4'h4, CSR page select, matched against csr_a[13:10].
REQ-002 sys_clk  in  1  system clock; all logic on rising edge.
REQ-003 sys_rst  in  1  reset, synchronous, active-high.
REQ-004 csr_a  in  14  CSR address; csr_a[2:0] selects the register.
REQ-005 csr_we  in  1  CSR write strobe.
REQ-006 csr_di  in  32  CSR write data.
REQ-007 csr_do  out  32  CSR read data; zero when page not selected, so it can be OR-combined.
REQ-008 irq  out  1  completion interrupt, level.
REQ-009 wb_adr_o  out  32  Wishbone byte address, bits [1:0] always 0.
REQ-010 wb_dat_o  out  32  write data.
REQ-011 wb_sel_o  out  4  constant 4'hf.
REQ-012 wb_cti_o  out  3  cycle type.
REQ-013 wb_bte_o  out  2  constant 2'b00.
REQ-014 wb_cyc_o / wb_stb_o  out  1 each  bus cycle / strobe.
REQ-015 wb_we_o  out  1  constant 1.
REQ-016 wb_ack_i  in  1  slave acknowledge.

Function
REQ-017 Registers: 0 CTRL (W: bit0 start, bit1 abort; reads 0), 1 STATUS (bit0 busy, bit1 done, bit2 aborted; writing 1 clears bits 1/2), 2 BASE (32 bit, [1:0] read 0), 3 COUNT (words, 24 bit), 4 PATTERN (32 bit), 5 STEP (32 bit), 6 IRQ_EN (bit0).
REQ-018 csr_do is registered: data appears the cycle after csr_a is presented; unimplemented offsets read 0.
REQ-019 Beat n (0-based) writes data PATTERN + n*STEP (mod 2^32) to address BASE + 4n (mod 2^32).
REQ-020 FSM states IDLE, XFER, GAP, FINISH; start in IDLE with COUNT>0 -> XFER next cycle, busy=1.
REQ-021 Start with COUNT=0 -> FINISH directly, no bus cycle, done set 2 cycles after the write.
REQ-022 Start while busy is ignored; BASE/COUNT/PATTERN/STEP writes while busy are ignored.
REQ-023 In XFER, cyc/stb stay high; a beat completes on a cycle with stb & ack; address/data advance the same edge.
REQ-024 Burst length = min(remaining, 8 - wb_adr_o[4:2]); bursts never cross a 32-byte boundary.
REQ-025 After the last beat of a burst: if words remain -> GAP (cyc=stb=0, one cycle) -> XFER; else -> FINISH.
REQ-026 FINISH: busy=0, done=1 (or aborted=1 if aborted), -> IDLE, one cycle.
REQ-027 Abort while busy: current burst completes in full, then FINISH with aborted=1 and done=0; abort in IDLE is ignored.
REQ-028 irq = done & IRQ_EN; simultaneous done set and W1C clear: set wins.
REQ-029 Counter of remaining words is 24 bit; COUNT=24'hFFFFFF is legal.

Reset
REQ-030 sys_rst on any edge: FSM -> IDLE, cyc=stb=0, cti=0, adr=0, dat=0, csr_do=0, irq=0, all registers 0, including mid-burst; no completion of the outstanding beat.

Configuration
REQ-031 Macro FB_FILL_BURST_EN defined: bursts per REQ-024, cti=3'b010 on all beats except the last beat of a burst, which uses 3'b111 (single-beat burst: 3'b111).
REQ-032 Without FB_FILL_BURST_EN: every beat is a classic cycle, cti=3'b000, burst length 1, GAP cycle after each ack.

Structure
REQ-033 Shared package fb_fill_pkg holds register offsets, STATUS bit indices, CTI constants, and the FSM state encoding.
REQ-034 One sub-module, fb_fill_csr (register file, csr_do mux, W1C logic); FSM and datapath stay in fb_fill_dma.

Verification
REQ-035 BASE=0x20000000, COUNT=8, PATTERN=0xA5A5A5A5, STEP=0, ack always -> one burst, 8 writes, cti 010x7 then 111, done=1.
REQ-036 BASE=0x20000018, COUNT=5, PATTERN=0, STEP=1 -> bursts of 2 (0x18,0x1C) and 3 (0x20..0x28), data 0..4, one GAP cycle between them.
REQ-037 COUNT=0, IRQ_EN=1, start -> no cyc; done and irq rise 2 cycles after the write; W1C to STATUS drops irq next cycle.
REQ-038 COUNT=20, random ack stalls, abort during beat 3 -> beats 0..7 complete, then aborted=1, done=0, no further cyc.
REQ-039 sys_rst asserted mid-burst with stb high -> next edge cyc=stb=0, STATUS=0, csr_do=0.
REQ-040 Build without FB_FILL_BURST_EN, COUNT=3 -> three cti=000 cycles, each followed by cyc low for one cycle.

Source files
------------

// File: rtl/fb_fill_pkg.sv
// fb_fill_pkg: shared definitions for the fb_fill_dma block.
//   - CSR register offsets (csr_a[2:0])
//   - STATUS and CTRL bit positions
//   - Wishbone cycle-type (CTI) codes
//   - FSM state encoding
package fb_fill_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_BASE    = 3'd2;
    localparam logic [2:0] REG_COUNT   = 3'd3;
    localparam logic [2:0] REG_PATTERN = 3'd4;
    localparam logic [2:0] REG_STEP    = 3'd5;
    localparam logic [2:0] REG_IRQ_EN  = 3'd6;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ABORTED = 2;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/fb_fill_csr.sv
// fb_fill_csr: CSR register file for fb_fill_dma.
// Holds BASE/COUNT/PATTERN/STEP/IRQ_EN and the sticky done/aborted flags,
// decodes CTRL writes into one-cycle start/abort pulses and produces the
// registered read data (zero whenever the page is not selected, so several
// CSR slaves can be OR-combined).
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   csr_a, csr_we, csr_di     CSR bus in; csr_a[13:10] page, csr_a[2:0] register
//   csr_do                    registered read data
//   i_busy                    transfer in progress (blocks parameter writes)
//   i_set_done/i_set_aborted  completion events from the FSM
//   o_start/o_abort           CTRL write pulses
//   o_base..o_irq_en          register values
//   o_done/o_aborted          sticky status flags
module fb_fill_csr
    import fb_fill_pkg::*;
#(
    parameter logic [3:0] csr_addr = 4'h4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    input  logic        i_busy,
    input  logic        i_set_done,
    input  logic        i_set_aborted,
    output logic        o_start,
    output logic        o_abort,
    output logic [31:0] o_base,
    output logic [23:0] o_count,
    output logic [31:0] o_pattern,
    output logic [31:0] o_step,
    output logic        o_irq_en,
    output logic        o_done,
    output logic        o_aborted
);

    logic [31:2] r_base;
    logic [23:0] r_count;
    logic [31:0] r_pattern;
    logic [31:0] r_step;
    logic        r_irq_en;
    logic        r_done;
    logic        r_aborted;
    logic [31:0] r_csr_do;

    logic        w_sel;
    logic        w_wr;
    logic [2:0]  w_off;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel    = (csr_a[13:10] == csr_addr);
    assign w_wr     = w_sel & csr_we;
    assign w_off    = csr_a[2:0];
    assign w_unused = ^csr_a[9:3];

    assign o_start   = w_wr && (w_off == REG_CTRL) && csr_di[CTRL_START];
    assign o_abort   = w_wr && (w_off == REG_CTRL) && csr_di[CTRL_ABORT];
    assign o_base    = {r_base, 2'b00};
    assign o_count   = r_count;
    assign o_pattern = r_pattern;
    assign o_step    = r_step;
    assign o_irq_en  = r_irq_en;
    assign o_done    = r_done;
    assign o_aborted = r_aborted;
    assign csr_do    = r_csr_do;

    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            REG_STATUS:  w_rdata = {29'd0, r_aborted, r_done, i_busy};
            REG_BASE:    w_rdata = {r_base, 2'b00};
            REG_COUNT:   w_rdata = {8'd0, r_count};
            REG_PATTERN: w_rdata = r_pattern;
            REG_STEP:    w_rdata = r_step;
            REG_IRQ_EN:  w_rdata = {31'd0, r_irq_en};
            default:     w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_base    <= '0;
            r_count   <= '0;
            r_pattern <= '0;
            r_step    <= '0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_csr_do  <= '0;
        end else begin
            // Transfer parameters are frozen while a transfer runs.
            if (w_wr && !i_busy) begin
                case (w_off)
                    REG_BASE:    r_base    <= csr_di[31:2];
                    REG_COUNT:   r_count   <= csr_di[23:0];
                    REG_PATTERN: r_pattern <= csr_di;
                    REG_STEP:    r_step    <= csr_di;
                    default:     ;
                endcase
            end
            if (w_wr && (w_off == REG_IRQ_EN))
                r_irq_en <= csr_di[0];
            // Completion event takes priority over a same-cycle W1C.
            if (i_set_done)
                r_done <= 1'b1;
            else if (w_wr && (w_off == REG_STATUS) && csr_di[ST_DONE])
                r_done <= 1'b0;
            if (i_set_aborted)
                r_aborted <= 1'b1;
            else if (w_wr && (w_off == REG_STATUS) && csr_di[ST_ABORTED])
                r_aborted <= 1'b0;
            r_csr_do <= w_sel ? w_rdata : 32'd0;
        end
    end

endmodule

// File: rtl/fb_fill_dma.sv
// fb_fill_dma: framebuffer fill DMA. Writes COUNT words to memory starting
// at BASE; word n carries PATTERN + n*STEP and goes to BASE + 4n.
// Wishbone master (write-only) plus a CSR slave page.
// Build option: define FB_FILL_BURST_EN for incrementing bursts that never
// cross a 32-byte boundary (cti 010 ... 111); otherwise every beat is a
// classic cycle (cti 000) followed by one idle cycle.
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   csr_a/csr_we/csr_di     CSR write/address inputs; csr_do registered read data
//   irq                     level interrupt = done & IRQ_EN
//   wb_*                    Wishbone master; a beat completes on stb & ack
//   o_dbg_state             current FSM state (fb_fill_pkg::state_t encoding)
module fb_fill_dma
    import fb_fill_pkg::*;
#(
    parameter logic [3:0] csr_addr = 4'h4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    output logic [1:0]  o_dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic [31:2] r_adr;
    logic [31:0] r_dat;
    logic [23:0] r_remaining;
    logic        r_abort;

    logic        w_start;
    logic        w_abort_pulse;
    logic        w_busy;
    logic        w_set_done;
    logic        w_set_aborted;
    logic        w_done;
    logic        w_aborted;
    logic        w_irq_en;
    logic [31:0] w_base;
    logic [23:0] w_count;
    logic [31:0] w_pattern;
    logic [31:0] w_step;
    logic        w_beat;
    logic        w_last_word;
    logic        w_burst_end;
    logic        w_abort_pend;

    fb_fill_csr #(
        .csr_addr (csr_addr)
    ) u_csr (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .csr_a         (csr_a),
        .csr_we        (csr_we),
        .csr_di        (csr_di),
        .csr_do        (csr_do),
        .i_busy        (w_busy),
        .i_set_done    (w_set_done),
        .i_set_aborted (w_set_aborted),
        .o_start       (w_start),
        .o_abort       (w_abort_pulse),
        .o_base        (w_base),
        .o_count       (w_count),
        .o_pattern     (w_pattern),
        .o_step        (w_step),
        .o_irq_en      (w_irq_en),
        .o_done        (w_done),
        .o_aborted     (w_aborted)
    );

    assign wb_adr_o    = {r_adr, 2'b00};
    assign wb_dat_o    = r_dat;
    assign wb_sel_o    = 4'hf;
    assign wb_bte_o    = 2'b00;
    assign wb_we_o     = 1'b1;
    assign irq         = w_done & w_irq_en;
    assign o_dbg_state = r_state;

    assign w_last_word  = (r_remaining == 24'd1);
    // An abort arriving on the same cycle as the final beat still counts.
    assign w_abort_pend = r_abort | w_abort_pulse;

    // A burst ends on the last word or on the last word slot of a 32-byte
    // line, which together give min(remaining, 8 - adr[4:2]) beats.
`ifdef FB_FILL_BURST_EN
    assign w_burst_end = w_last_word | (r_adr[4:2] == 3'b111);
`else
    assign w_burst_end = 1'b1;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_busy        = 1'b0;
        wb_cyc_o      = 1'b0;
        wb_stb_o      = 1'b0;
        wb_cti_o      = CTI_CLASSIC;
        w_set_done    = 1'b0;
        w_set_aborted = 1'b0;
        w_beat        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start)
                    w_next = (w_count == 24'd0) ? S_FINISH : S_XFER;
            end
            S_XFER: begin
                w_busy   = 1'b1;
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                w_beat   = wb_ack_i;
`ifdef FB_FILL_BURST_EN
                wb_cti_o = w_burst_end ? CTI_END : CTI_INCR;
`endif
                if (wb_ack_i && w_burst_end)
                    w_next = (w_last_word || w_abort_pend) ? S_FINISH : S_GAP;
            end
            S_GAP: begin
                w_busy = 1'b1;
                w_next = w_abort_pend ? S_FINISH : S_XFER;
            end
            S_FINISH: begin
                w_set_done    = ~r_abort;
                w_set_aborted = r_abort;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_adr       <= '0;
            r_dat       <= '0;
            r_remaining <= '0;
            r_abort     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_start) begin
                r_adr       <= w_base[31:2];
                r_dat       <= w_pattern;
                r_remaining <= w_count;
                r_abort     <= 1'b0;
            end
            if (w_beat) begin
                r_adr       <= r_adr + 30'd1;
                r_dat       <= r_dat + w_step;
                r_remaining <= r_remaining - 24'd1;
            end
            if (w_busy && w_abort_pulse)
                r_abort <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_fill_dma.sv
// tb_fb_fill_dma: self-checking bench for fb_fill_dma.
// Expected bus beats come from a word-level model of the fill rules
// (address/data per word, bursts cut at min(remaining, 8 - word slot)).
`timescale 1ns/1ps
module tb_fb_fill_dma;

    localparam logic [3:0] PAGE = 4'h4;
    localparam logic [2:0] O_CTRL = 3'd0, O_STATUS = 3'd1, O_BASE = 3'd2, O_COUNT = 3'd3;
    localparam logic [2:0] O_PATTERN = 3'd4, O_STEP = 3'd5, O_IRQ_EN = 3'd6;
`ifdef FB_FILL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic        wb_ack_i;
    logic [1:0]  dbg_state;

    fb_fill_dma #(.csr_addr(PAGE)) dut (
        .sys_clk (sys_clk), .sys_rst (sys_rst),
        .csr_a (csr_a), .csr_we (csr_we), .csr_di (csr_di), .csr_do (csr_do),
        .irq (irq),
        .wb_adr_o (wb_adr_o), .wb_dat_o (wb_dat_o), .wb_sel_o (wb_sel_o),
        .wb_cti_o (wb_cti_o), .wb_bte_o (wb_bte_o), .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o), .wb_we_o (wb_we_o), .wb_ack_i (wb_ack_i),
        .o_dbg_state (dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    // {burst_end, cti, adr, dat}
    logic [67:0] exp_q[$];
    int  beats_done = 0;
    bit  gap_wait = 0;
    int  gap_cnt = 0;
    bit  ack_hold = 0;
    bit  ack_rand = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- clock/reset helpers and drivers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic csr_write(input logic [2:0] off, input logic [31:0] d);
        tick();
        csr_a  = {PAGE, 7'd0, off};
        csr_di = d;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
        csr_a  = '0;
    endtask

    task automatic csr_read(input logic [2:0] off, output logic [31:0] d);
        tick();
        csr_a  = {PAGE, 7'd0, off};
        csr_we = 1'b0;
        tick();
        d     = csr_do;
        csr_a = '0;
    endtask

    task automatic wait_done(output logic [31:0] s);
        bit ok;
        ok = 1'b0;
        s  = '0;
        for (int i = 0; i < 1500; i++) begin
            csr_read(O_STATUS, s);
            if (s[1] || s[2]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 64'd0, 64'd1);
    endtask

    // Slave acknowledge: always, randomly stalled, or held off.
    initial begin
        wb_ack_i = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (ack_hold)      wb_ack_i = 1'b0;
            else if (ack_rand) wb_ack_i = ($urandom_range(0, 2) != 0);
            else               wb_ack_i = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    task automatic model_build(input logic [31:0] base, input int count,
                               input logic [31:0] pattern, input logic [31:0] step);
        logic [31:0] a, d;
        logic [2:0]  cti;
        int rem, len;
        exp_q.delete();
        a   = base & 32'hFFFF_FFFC;
        d   = pattern;
        rem = count;
        while (rem > 0) begin
            len = BURST ? (8 - int'(a[4:2])) : 1;
            if (rem < len) len = rem;
            for (int k = 0; k < len; k++) begin
                cti = !BURST ? 3'b000 : ((k == len - 1) ? 3'b111 : 3'b010);
                exp_q.push_back({(k == len - 1), cti, a, d});
                a = a + 32'd4;
                d = d + step;
                rem--;
            end
        end
        beats_done = 0;
        gap_wait   = 1'b0;
    endtask

    // ---------------- bus monitor / scoreboard ----------------
    always @(negedge sys_clk) begin
        logic [67:0] e;
        if (!sys_rst) begin
            if (gap_wait) begin
                if (!wb_cyc_o) begin
                    gap_cnt++;
                    if (gap_cnt > 20) begin
                        check("gap_timeout", 64'(gap_cnt), 64'd1);
                        gap_wait = 1'b0;
                    end
                end else begin
                    check("gap_len", 64'(gap_cnt), 64'd1);
                    gap_wait = 1'b0;
                end
            end
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {32'd0, wb_adr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_adr", 64'(wb_adr_o), 64'(e[63:32]));
                    check("beat_dat", 64'(wb_dat_o), 64'(e[31:0]));
                    check("beat_cti", 64'(wb_cti_o), 64'(e[66:64]));
                    check("beat_ctl", {57'd0, wb_sel_o, wb_we_o, wb_bte_o},
                          {57'd0, 4'hf, 1'b1, 2'b00});
                    beats_done++;
                    if (e[67] && exp_q.size() > 0) begin
                        gap_wait = 1'b1;
                        gap_cnt  = 0;
                    end
                end
            end
        end
    end

    task automatic run_xfer(input logic [31:0] base, input int count, input logic [31:0] pattern,
                            input logic [31:0] step, input bit rnd, input bit poke);
        logic [31:0] s, r;
        ack_rand = rnd;
        csr_write(O_BASE, base);
        csr_write(O_COUNT, count);
        csr_write(O_PATTERN, pattern);
        csr_write(O_STEP, step);
        model_build(base, count, pattern, step);
        csr_write(O_CTRL, 32'h1);
        if (poke) begin
            // Restart and parameter writes while busy must not take effect.
            csr_write(O_CTRL, 32'h1);
            csr_write(O_BASE, ~base);
        end
        wait_done(s);
        check("xfer_status", 64'(s), 64'h2);
        check("xfer_left", 64'(exp_q.size()), 64'd0);
        check("xfer_beats", 64'(beats_done), 64'(count));
        if (poke) begin
            csr_read(O_BASE, r);
            check("busy_base_kept", 64'(r), 64'(base & 32'hFFFF_FFFC));
        end
        csr_write(O_STATUS, 32'h6);
        csr_read(O_STATUS, s);
        check("status_cleared", 64'(s), 64'h0);
        ack_rand = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        vec_t vt[8];
        logic [31:0] s, r;
        bit found;
        int keep;

        vt[0] = '{3'd2, 32'h1234_5677, 32'h1234_5674};
        vt[1] = '{3'd3, 32'hFFFF_FFFF, 32'h00FF_FFFF};
        vt[2] = '{3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[3] = '{3'd5, 32'h0000_0010, 32'h0000_0010};
        vt[4] = '{3'd6, 32'hFFFF_FFFE, 32'h0000_0000};
        vt[5] = '{3'd6, 32'h0000_0003, 32'h0000_0001};
        vt[6] = '{3'd0, 32'h0000_0000, 32'h0000_0000};
        vt[7] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};

        sys_rst = 1'b1;
        csr_a   = '0;
        csr_we  = 1'b0;
        csr_di  = '0;
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();

        // Reset state
        check("rst_csr_do", 64'(csr_do), 64'd0);
        check("rst_cyc_stb", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
        check("rst_adr", 64'(wb_adr_o), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        check("rst_cti", 64'(wb_cti_o), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        csr_read(O_STATUS, s);
        check("rst_status", 64'(s), 64'd0);

        // Register write/readback table
        for (int i = 0; i < 8; i++) begin
            csr_write(vt[i].off, vt[i].wdata);
            csr_read(vt[i].off, r);
            check($sformatf("reg_rb_%0d", i), 64'(r), 64'(vt[i].exp_rd));
        end
        // Other page must read as zero.
        tick();
        csr_a = {4'h5, 7'd0, O_STEP};
        tick();
        check("page_unsel", 64'(csr_do), 64'd0);
        check("irq_no_done", 64'(irq), 64'd0);
        csr_write(O_IRQ_EN, 32'h0);

        // Single aligned burst, constant data, with busy-time pokes
        run_xfer(32'h2000_0000, 8, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1);
        // Burst split at 32-byte line
        run_xfer(32'h2000_0018, 5, 32'h0, 32'h1, 1'b0, 1'b0);
        // Short run
        run_xfer(32'h0000_0100, 3, 32'h7, 32'h2, 1'b0, 1'b0);

        // COUNT=0: no bus cycle, done/irq two cycles after the write
        csr_write(O_IRQ_EN, 32'h1);
        csr_write(O_COUNT, 32'h0);
        model_build(32'h0, 0, 32'h0, 32'h0);
        csr_write(O_CTRL, 32'h1);
        check("cnt0_irq_early", 64'(irq), 64'd0);
        check("cnt0_cyc_a", 64'(wb_cyc_o), 64'd0);
        tick();
        check("cnt0_irq_set", 64'(irq), 64'd1);
        check("cnt0_cyc_b", 64'(wb_cyc_o), 64'd0);
        csr_read(O_STATUS, s);
        check("cnt0_status", 64'(s), 64'h2);
        check("cnt0_irq_hold", 64'(irq), 64'd1);
        csr_write(O_STATUS, 32'h2);
        check("cnt0_irq_clr", 64'(irq), 64'd0);
        csr_write(O_IRQ_EN, 32'h0);

        // Abort during beat 3 with random stalls
        ack_rand = 1'b1;
        csr_write(O_BASE, 32'h0000_1000);
        csr_write(O_COUNT, 32'd20);
        csr_write(O_PATTERN, 32'h100);
        csr_write(O_STEP, 32'h3);
        model_build(32'h0000_1000, 20, 32'h100, 32'h3);
        csr_write(O_CTRL, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            #1;
            // beats_done reaches 3 on the cycle beat 2 is acked; hold ack
            // from the next cycle so beat 3 stays outstanding.
            if (beats_done == 3) begin
                ack_hold = 1'b1;
                found = 1'b1;
                break;
            end
        end
        if (!found) check("abort_reach_beat3", 64'(beats_done), 64'd3);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            #1;
            if (wb_cyc_o) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("abort_beat3_cyc", 64'd0, 64'd1);
        csr_write(O_CTRL, 32'h2);
        // Keep beats up to the end of the burst containing beat 3.
        keep = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][67]) begin
                keep = i + 1;
                break;
            end
        end
        while (exp_q.size() > keep) void'(exp_q.pop_back());
        ack_hold = 1'b0;
        wait_done(s);
        check("abort_status", 64'(s), 64'h4);
        check("abort_left", 64'(exp_q.size()), 64'd0);
        check("abort_beats", 64'(beats_done), BURST ? 64'd8 : 64'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_cyc", 64'(wb_cyc_o), 64'd0);
        end
        csr_write(O_STATUS, 32'h4);
        csr_read(O_STATUS, s);
        check("abort_status_clr", 64'(s), 64'h0);
        ack_rand = 1'b0;

        // Randomized transfers
        for (int t = 0; t < 6; t++) begin
            run_xfer($urandom, $urandom_range(1, 20), $urandom, $urandom, 1'b1, 1'b0);
        end

        // Reset mid-burst with stb high
        ack_hold = 1'b1;
        csr_write(O_BASE, 32'h0000_0040);
        csr_write(O_COUNT, 32'd20);
        csr_write(O_IRQ_EN, 32'h1);
        model_build(32'h0000_0040, 20, 32'h0, 32'h0);
        csr_write(O_CTRL, 32'h1);
        tick();
        tick();
        check("pre_rst_stb", 64'(wb_stb_o), 64'd1);
        sys_rst = 1'b1;
        tick();
        check("mid_rst_cyc_stb", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
        check("mid_rst_csr_do", 64'(csr_do), 64'd0);
        check("mid_rst_adr", 64'(wb_adr_o), 64'd0);
        check("mid_rst_dat", 64'(wb_dat_o), 64'd0);
        check("mid_rst_cti", 64'(wb_cti_o), 64'd0);
        check("mid_rst_irq", 64'(irq), 64'd0);
        exp_q.delete();
        gap_wait = 1'b0;
        sys_rst  = 1'b0;
        ack_hold = 1'b0;
        csr_read(O_STATUS, s);
        check("post_rst_status", 64'(s), 64'd0);
        csr_read(O_COUNT, s);
        check("post_rst_count", 64'(s), 64'd0);
        tick();
        check("post_rst_cyc", 64'(wb_cyc_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
